// File: rtl/led_pwm_fader.sv
// N-channel LED PWM driver with steady / ramp / blink / off modes per channel.
// Each channel owns a phase-staggered period counter; duty changes land only on that channel's wrap.
module led_pwm_fader #(
    parameter int parm_channel_count          = 8,
    parameter int parm_duty_bits              = 8,
    parameter int parm_FCLK                   = 40_000_000,
    parameter int parm_pwm_period_milliseconds = 10,
    parameter int parm_max_duty_percent       = 90,
    parameter int parm_blink_periods          = 50,
    parameter int parm_phase_stagger          = 1
) (
    input  logic                                         i_clk,
    input  logic                                         i_arstn,
    input  logic [parm_channel_count*parm_duty_bits-1:0] i_target_value,
    input  logic [2*parm_channel_count-1:0]              i_mode,
    input  logic [parm_duty_bits-1:0]                    i_ramp_step,
    output logic [parm_channel_count-1:0]                eo_leds,
    output logic                                         o_period_strobe,
    output logic [parm_channel_count-1:0]                o_ramp_done
);

    localparam int N     = parm_channel_count;
    localparam int W     = parm_duty_bits;
    localparam int C_P   = parm_FCLK / 1000 * parm_pwm_period_milliseconds;
    localparam int C_MAX = C_P * parm_max_duty_percent / 100;
    localparam int C_R   = C_MAX / ((2 ** W) - 1);
    localparam int CW    = $clog2(C_P);
    localparam int BW    = (parm_blink_periods > 1) ? $clog2(parm_blink_periods) : 1;

    localparam logic [CW-1:0] CR_V = CW'(C_R);

    typedef enum logic [1:0] {
        MODE_STEADY = 2'b00,
        MODE_RAMP   = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    generate
        if (C_R < 1) begin : g_bad_cfg
            $error("led_pwm_fader: duty step per level is zero; lengthen the period or reduce duty bits");
        end
    endgenerate

    logic [N-1:0] wrap_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            localparam int OFFSET = (parm_phase_stagger != 0) ? gi * (C_P / N) : 0;

            logic [CW-1:0] cnt_q, cnt_d;
            logic [W-1:0]  level_q, level_d;
            logic [CW-1:0] prod1_q, prod2_q, duty_q;
            logic [BW-1:0] bcnt_q, bcnt_d;
            logic          phase_q, phase_d;
            logic          wrap;
            logic [W-1:0]  tgt;
            mode_e         md;
            logic [W:0]    sum;

            assign tgt         = i_target_value[gi*W +: W];
            assign md          = mode_e'(i_mode[2*gi +: 2]);
            assign wrap        = (cnt_q == CW'(C_P - 1));
            assign wrap_vec[gi] = wrap;

            always_comb begin
                cnt_d   = wrap ? '0 : cnt_q + 1'b1;
                level_d = level_q;
                bcnt_d  = bcnt_q;
                phase_d = phase_q;
                // Extra carry bit keeps an upward ramp from wrapping past the top level
                sum     = {1'b0, level_q} + {1'b0, i_ramp_step};
                if (wrap) begin
                    case (md)
                        MODE_STEADY: level_d = tgt;
                        MODE_OFF:    level_d = '0;
                        MODE_RAMP: begin
                            if (level_q < tgt) begin
                                level_d = (sum > {1'b0, tgt}) ? tgt : sum[W-1:0];
                            end else if (level_q > tgt) begin
                                level_d = ((level_q - tgt) <= i_ramp_step) ? tgt : level_q - i_ramp_step;
                            end
                        end
                        MODE_BLINK: begin
                            level_d = phase_q ? tgt : '0;
                            if (bcnt_q == BW'(parm_blink_periods - 1)) begin
                                bcnt_d  = '0;
                                phase_d = ~phase_q;
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                        default: level_d = level_q;
                    endcase
                end
                if (md != MODE_BLINK) begin
                    bcnt_d  = '0;
                    phase_d = 1'b0;
                end
            end

            always_ff @(posedge i_clk or negedge i_arstn) begin
                if (!i_arstn) begin
                    cnt_q           <= CW'(OFFSET);
                    level_q         <= '0;
                    prod1_q         <= '0;
                    prod2_q         <= '0;
                    duty_q          <= '0;
                    bcnt_q          <= '0;
                    phase_q         <= 1'b0;
                    eo_leds[gi]     <= 1'b0;
                    o_ramp_done[gi] <= 1'b1;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    bcnt_q  <= bcnt_d;
                    phase_q <= phase_d;
                    prod1_q <= CW'(level_q) * CR_V;
                    prod2_q <= prod1_q;
                    // Duty only moves at the wrap so a running period is never cut short
                    if (wrap) begin
                        duty_q <= prod2_q;
                    end
                    eo_leds[gi]     <= (cnt_q < duty_q);
                    o_ramp_done[gi] <= (level_q == tgt);
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            o_period_strobe <= 1'b0;
        end else begin
            o_period_strobe <= wrap_vec[0];
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomised and directed bench for led_pwm_fader against a per-period behavioural model.
// The model tracks count, level and per-period duty with plain integers; literal checks pin it.
module tb_led_pwm_fader;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int FCLK = 100_000;
    localparam int PMS  = 1;
    localparam int PCT  = 90;
    localparam int BP   = 3;
    localparam int STG  = 1;
    localparam int CP   = FCLK / 1000 * PMS;
    localparam int CR   = (CP * PCT / 100) / ((2 ** W) - 1);
    localparam int HMAX = 2000;

    logic             i_clk = 1'b0;
    logic             i_arstn = 1'b0;
    logic [N*W-1:0]   i_target_value = '0;
    logic [2*N-1:0]   i_mode = '0;
    logic [W-1:0]     i_ramp_step = '0;
    logic [N-1:0]     eo_leds;
    logic             o_period_strobe;
    logic [N-1:0]     o_ramp_done;

    led_pwm_fader #(
        .parm_channel_count(N), .parm_duty_bits(W), .parm_FCLK(FCLK),
        .parm_pwm_period_milliseconds(PMS), .parm_max_duty_percent(PCT),
        .parm_blink_periods(BP), .parm_phase_stagger(STG)
    ) dut (
        .i_clk(i_clk), .i_arstn(i_arstn), .i_target_value(i_target_value),
        .i_mode(i_mode), .i_ramp_step(i_ramp_step), .eo_leds(eo_leds),
        .o_period_strobe(o_period_strobe), .o_ramp_done(o_ramp_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: count, level, duty of the running period, blink counter and phase
    int           m_cnt [N];
    int           m_lvl [N];
    int           m_duty[N];
    int           m_bc  [N];
    bit           m_ph  [N];
    logic [N-1:0] e_leds;
    logic [N-1:0] e_done;
    logic         e_strobe;

    logic [N-1:0] h_leds[HMAX];
    logic [N-1:0] h_done[HMAX];
    int           edge_n;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k]  = (STG != 0) ? k * (CP / N) : 0;
            m_lvl[k]  = 0;
            m_duty[k] = 0;
            m_bc[k]   = 0;
            m_ph[k]   = 1'b0;
        end
        e_leds   = '0;
        e_done   = '1;
        e_strobe = 1'b0;
    endtask

    task automatic model_step();
        int tgt, md, st;
        st = int'(i_ramp_step);
        e_strobe = (m_cnt[0] == CP - 1);
        for (int k = 0; k < N; k++) begin
            tgt = int'(i_target_value[k*W +: W]);
            md  = int'(i_mode[2*k +: 2]);
            e_leds[k] = (m_cnt[k] < m_duty[k]);
            e_done[k] = (m_lvl[k] == tgt);
            if (m_cnt[k] == CP - 1) begin
                // New period runs with the duty of the level held through the last one
                m_duty[k] = m_lvl[k] * CR;
                case (md)
                    0: m_lvl[k] = tgt;
                    3: m_lvl[k] = 0;
                    1: begin
                        if (m_lvl[k] < tgt)      m_lvl[k] = (m_lvl[k] + st > tgt) ? tgt : m_lvl[k] + st;
                        else if (m_lvl[k] > tgt) m_lvl[k] = (m_lvl[k] - st < tgt) ? tgt : m_lvl[k] - st;
                    end
                    default: begin
                        m_lvl[k] = m_ph[k] ? tgt : 0;
                        if (m_bc[k] == BP - 1) begin
                            m_bc[k] = 0;
                            m_ph[k] = ~m_ph[k];
                        end else begin
                            m_bc[k]++;
                        end
                    end
                endcase
                m_cnt[k] = 0;
            end else begin
                m_cnt[k]++;
            end
            if (md != 2) begin
                m_bc[k] = 0;
                m_ph[k] = 1'b0;
            end
        end
    endtask

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            edge_n++;
            model_step();
            @(negedge i_clk);
            check("leds", int'(eo_leds), int'(e_leds));
            check("strobe", int'(o_period_strobe), int'(e_strobe));
            check("ramp_done", int'(o_ramp_done), int'(e_done));
            if (edge_n < HMAX) begin
                h_leds[edge_n] = eo_leds;
                h_done[edge_n] = o_ramp_done;
            end
        end
    endtask

    task automatic set_all(input int md, input int tgt, input int st);
        for (int k = 0; k < N; k++) begin
            i_mode[2*k +: 2]         = 2'(md);
            i_target_value[k*W +: W] = W'(tgt);
        end
        i_ramp_step = W'(st);
    endtask

    task automatic do_reset(input int md, input int tgt, input int st);
        @(negedge i_clk);
        i_arstn = 1'b0;
        set_all(md, tgt, st);
        model_reset();
        repeat (2) @(negedge i_clk);
        i_arstn   = 1'b1;
        edge_n    = 0;
        h_leds[0] = '0;
        h_done[0] = '1;
    endtask

    function automatic int high_count(input int k, input int from, input int to);
        int c = 0;
        for (int e = from; e <= to; e++) c += int'(h_leds[e][k]);
        return c;
    endfunction

    function automatic int first_rise(input int k);
        for (int e = 1; e < HMAX; e++)
            if (h_leds[e][k] && !h_leds[e-1][k]) return e;
        return -1;
    endfunction

    task automatic check_steady15_rises(input string tag);
        check({tag, "_rise_ch0"}, first_rise(0), 201);
        check({tag, "_rise_ch1"}, first_rise(1), 176);
        check({tag, "_rise_ch2"}, first_rise(2), 151);
        check({tag, "_rise_ch3"}, first_rise(3), 126);
        check({tag, "_high_ch0"}, high_count(0, 201, 300), 90);
    endtask

    initial begin
        model_reset();
        edge_n = 0;

        // Reset state and steady full level
        do_reset(0, 15, 0);
        check("reset_leds", int'(eo_leds), 0);
        check("reset_strobe", int'(o_period_strobe), 0);
        check("reset_done", int'(o_ramp_done), 15);
        step_cycles(300);
        check_steady15_rises("steady15");
        check("strobe_at_101", int'(h_leds[100][0]), 0);

        // Steady zero: never on
        do_reset(0, 0, 0);
        step_cycles(300);
        for (int k = 0; k < N; k++) check("zero_high", high_count(k, 1, 300), 0);
        check("zero_done", int'(h_done[300]), 15);

        // Ramp up by 4 toward 15
        do_reset(1, 15, 4);
        step_cycles(600);
        check("ramp_up_p2", high_count(0, 201, 300), 24);
        check("ramp_up_p3", high_count(0, 301, 400), 48);
        check("ramp_up_p4", high_count(0, 401, 500), 72);
        check("ramp_up_p5", high_count(0, 501, 600), 90);
        check("ramp_done_400", int'(h_done[400][0]), 0);
        check("ramp_done_401", int'(h_done[401][0]), 1);

        // Ramp down from 15 to 2 by 5, no underflow
        do_reset(0, 15, 0);
        step_cycles(100);
        set_all(1, 2, 5);
        step_cycles(600);
        check("ramp_dn_p2", high_count(0, 201, 300), 90);
        check("ramp_dn_p3", high_count(0, 301, 400), 60);
        check("ramp_dn_p4", high_count(0, 401, 500), 30);
        check("ramp_dn_p5", high_count(0, 501, 600), 12);
        check("ramp_dn_p6", high_count(0, 601, 700), 12);

        // Blink at level 8, three periods per half-cycle
        do_reset(2, 8, 0);
        step_cycles(1200);
        for (int p = 5; p < 12; p++)
            check("blink_period", high_count(0, p*100 + 1, p*100 + 100), (p < 8 || p == 11) ? 48 : 0);

        // Asynchronous reset while a channel is driving high
        do_reset(0, 15, 0);
        step_cycles(250);
        check("pre_arst_led0", int'(eo_leds[0]), 1);
        @(posedge i_clk);
        #2 i_arstn = 1'b0;
        model_reset();
        #1;
        check("arst_leds", int'(eo_leds), 0);
        check("arst_strobe", int'(o_period_strobe), 0);
        check("arst_done", int'(o_ramp_done), 15);
        repeat (2) @(negedge i_clk);
        i_arstn   = 1'b1;
        edge_n    = 0;
        h_leds[0] = '0;
        step_cycles(300);
        check_steady15_rises("after_arst");

        // Random modes, targets and steps, changed at arbitrary cycles
        do_reset(0, 0, 0);
        repeat (25) begin
            for (int k = 0; k < N; k++) begin
                i_mode[2*k +: 2]         = 2'($urandom_range(0, 3));
                i_target_value[k*W +: W] = W'($urandom_range(0, 15));
            end
            i_ramp_step = W'($urandom_range(0, 15));
            step_cycles($urandom_range(20, 250));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
